// File: rtl/coeff_loader.sv
// Register-bus initiator: writes the mode GPR, streams FIR coefficients into the
// coefficient registers, reads them back and flags a checksum mismatch.
module coeff_loader #(
    parameter int DATA_WIDTH      = 16,
    parameter int NUM_GPR_REGS    = 1,
    parameter int NUM_COEFFS_REGS = 30,
    parameter int READ_LATENCY    = 1,
    localparam int ADDR_W         = $clog2(NUM_GPR_REGS + NUM_COEFFS_REGS),
    localparam int CSUM_W         = DATA_WIDTH + $clog2(NUM_COEFFS_REGS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] src_data_in,
    input  logic                  src_valid_in,
    output logic                  src_ready_out,
    output logic [ADDR_W-1:0]     addr,
    output logic                  write_en,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [CSUM_W-1:0]     checksum
);

    localparam int IDX_W  = $clog2(NUM_COEFFS_REGS + 1);
    localparam int WAIT_W = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_COEFFS_REGS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_LATENCY);
    localparam logic [ADDR_W-1:0] COEF_BASE = ADDR_W'(NUM_GPR_REGS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_GPR,
        S_LOAD,
        S_VERIFY,
        S_CHECK
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CSUM_W-1:0]   csum_q, csum_d;
    logic [CSUM_W-1:0]   rbsum_q, rbsum_d;
    logic                error_q, error_d;
    logic                done_q, done_d;
    logic [ADDR_W-1:0]   coef_addr;

    assign coef_addr = COEF_BASE + ADDR_W'(idx_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wait_q  <= '0;
            csum_q  <= '0;
            rbsum_q <= '0;
            error_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            csum_q  <= csum_d;
            rbsum_q <= rbsum_d;
            error_q <= error_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        wait_d        = wait_q;
        csum_d        = csum_q;
        rbsum_d       = rbsum_q;
        error_d       = error_q;
        done_d        = 1'b0;
        addr          = '0;
        write_en      = 1'b0;
        wdata         = '0;
        src_ready_out = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    csum_d  = '0;
                    rbsum_d = '0;
                    idx_d   = '0;
                    wait_d  = '0;
                    state_d = S_WR_GPR;
                end
            end

            S_WR_GPR: begin
                write_en = 1'b1;
                wdata[0] = mode;
                state_d  = S_LOAD;
            end

            // Write strobe follows the stream directly so a beat lands in the
            // register file in the same cycle it is accepted.
            S_LOAD: begin
                src_ready_out = 1'b1;
                write_en      = src_valid_in;
                addr          = coef_addr;
                wdata         = src_data_in;
                if (src_valid_in) begin
                    csum_d = csum_q + CSUM_W'(src_data_in);
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        wait_d  = '0;
                        state_d = S_VERIFY;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            // Address is held for READ_LATENCY+1 cycles; rdata is taken on the last.
            S_VERIFY: begin
                addr = coef_addr;
                if (wait_q == WAIT_LAST) begin
                    rbsum_d = rbsum_q + CSUM_W'(rdata);
                    wait_d  = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = S_CHECK;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            S_CHECK: begin
                error_d = (rbsum_q != csum_q);
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign error    = error_q;
    assign checksum = csum_q;

endmodule

// File: tb/tb_coeff_loader.sv
// Directed bench for coeff_loader: a 30-coefficient instance with a 1-cycle register
// model, plus two single-coefficient instances with read latencies 0 and 3.
module tb_coeff_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode = 1'b0;
    logic [15:0] src_data = '0;
    logic        src_valid = 1'b0;
    logic        corrupt = 1'b0;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // main instance: 30 coeffs, RL=1
    logic        start_m = 1'b0;
    logic        ready_m, we_m, busy_m, done_m, error_m;
    logic [4:0]  addr_m;
    logic [15:0] wdata_m, rdata_m;
    logic [20:0] csum_m;
    logic [15:0] mem_m [0:31];

    coeff_loader u_main (
        .clk(clk), .rst(rst), .start(start_m), .mode(mode),
        .src_data_in(src_data), .src_valid_in(src_valid), .src_ready_out(ready_m),
        .addr(addr_m), .write_en(we_m), .wdata(wdata_m), .rdata(rdata_m),
        .busy(busy_m), .done(done_m), .error(error_m), .checksum(csum_m)
    );

    always @(posedge clk) begin
        if (we_m) mem_m[addr_m] <= (corrupt && addr_m == 5'd5) ? wdata_m + 16'd1 : wdata_m;
        rdata_m <= mem_m[addr_m];
    end

    // instance A: 1 coeff, RL=0
    logic        start_a = 1'b0;
    logic        ready_a, we_a, busy_a, done_a, error_a;
    logic [0:0]  addr_a;
    logic [15:0] wdata_a, rdata_a;
    logic [16:0] csum_a;
    logic [15:0] mem_a [0:1];

    coeff_loader #(.NUM_COEFFS_REGS(1), .READ_LATENCY(0)) u_rl0 (
        .clk(clk), .rst(rst), .start(start_a), .mode(mode),
        .src_data_in(src_data), .src_valid_in(src_valid), .src_ready_out(ready_a),
        .addr(addr_a), .write_en(we_a), .wdata(wdata_a), .rdata(rdata_a),
        .busy(busy_a), .done(done_a), .error(error_a), .checksum(csum_a)
    );

    always @(posedge clk) if (we_a) mem_a[addr_a] <= wdata_a;
    assign rdata_a = mem_a[addr_a];

    // instance B: 1 coeff, RL=3
    logic        start_b = 1'b0;
    logic        ready_b, we_b, busy_b, done_b, error_b;
    logic [0:0]  addr_b;
    logic [15:0] wdata_b, rdata_b;
    logic [16:0] csum_b;
    logic [15:0] mem_b [0:1];
    logic [15:0] pipe_b [0:2];

    coeff_loader #(.NUM_COEFFS_REGS(1), .READ_LATENCY(3)) u_rl3 (
        .clk(clk), .rst(rst), .start(start_b), .mode(mode),
        .src_data_in(src_data), .src_valid_in(src_valid), .src_ready_out(ready_b),
        .addr(addr_b), .write_en(we_b), .wdata(wdata_b), .rdata(rdata_b),
        .busy(busy_b), .done(done_b), .error(error_b), .checksum(csum_b)
    );

    always @(posedge clk) begin
        if (we_b) mem_b[addr_b] <= wdata_b;
        pipe_b[0] <= mem_b[addr_b];
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign rdata_b = pipe_b[2];

    // monitors (sampled on the falling edge)
    int wr_cnt [3];
    int last_wr [3];
    int done_cnt [3];
    int done_cyc [3];
    int bad_we = 0;
    int wr_addr_q [$];
    int wr_data_q [$];
    int wr_cyc_q [$];

    initial begin
        for (int i = 0; i < 3; i++) begin
            wr_cnt[i] = 0; last_wr[i] = 0; done_cnt[i] = 0; done_cyc[i] = 0;
        end
    end

    always @(negedge clk) begin
        if (we_m) begin
            wr_cnt[0]++; last_wr[0] = cyc;
            wr_addr_q.push_back(int'(addr_m));
            wr_data_q.push_back(int'(wdata_m));
            wr_cyc_q.push_back(cyc);
            if (addr_m != 5'd0 && !src_valid) bad_we++;
        end
        if (done_m) begin done_cnt[0]++; done_cyc[0] = cyc; end
        if (we_a) begin wr_cnt[1]++; last_wr[1] = cyc; end
        if (done_a) begin done_cnt[1]++; done_cyc[1] = cyc; end
        if (we_b) begin wr_cnt[2]++; last_wr[2] = cyc; end
        if (done_b) begin done_cnt[2]++; done_cyc[2] = cyc; end
    end

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic ready_of(input int w);
        case (w)
            0: return ready_m;
            1: return ready_a;
            default: return ready_b;
        endcase
    endfunction

    function automatic logic done_of(input int w);
        case (w)
            0: return done_m;
            1: return done_a;
            default: return done_b;
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 after the last beat is taken.
    task automatic stream_beats(input int w, input int n, input int first, input bit gaps);
        bit ok;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                int g = int'($urandom_range(0, 2));
                if (g > 0) begin
                    src_valid = 1'b0;
                    repeat (g) begin @(posedge clk); #1; end
                end
            end
            src_valid = 1'b1;
            src_data  = 16'(first + i);
            ok = 1'b0;
            for (int t = 0; t < 400 && !ok; t++) begin
                @(negedge clk);
                if (ready_of(w)) ok = 1'b1;
                @(posedge clk); #1;
            end
            if (!ok) begin
                check_val("beat_accept_timeout", 32'(ok), 32'd1);
                src_valid = 1'b0;
                return;
            end
        end
        src_valid = 1'b0;
    endtask

    // Leaves the bench on the negedge where done is high.
    task automatic wait_done(input int w, input string tag);
        bit ok = 1'b0;
        for (int t = 0; t < 500 && !ok; t++) begin
            @(negedge clk);
            if (done_of(w)) ok = 1'b1;
        end
        check_val({tag, "_done_seen"}, 32'(ok), 32'd1);
    endtask

    task automatic start_main(input logic mode_v, input int first);
        @(posedge clk); #1;
        mode = mode_v; start_m = 1'b1; src_valid = 1'b1; src_data = 16'(first);
        @(posedge clk); #1;
        start_m = 1'b0;
    endtask

    task automatic check_seq(input string tag, input int mode_v, input bit consecutive);
        int errs = 0;
        check_val({tag, "_nwr"}, 32'(wr_addr_q.size()), 32'd31);
        for (int i = 0; i < wr_addr_q.size(); i++) begin
            if (wr_addr_q[i] != i) errs++;
            if (wr_data_q[i] != ((i == 0) ? mode_v : i)) errs++;
            if (consecutive && wr_cyc_q[i] != wr_cyc_q[0] + i) errs++;
        end
        check_val({tag, "_seq"}, 32'(errs), 32'd0);
    endtask

    task automatic clear_log();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    endtask

    initial begin
        int d0;
        int w0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("rst_busy", 32'(busy_m), 32'd0);
        check_val("rst_done", 32'(done_m), 32'd0);
        check_val("rst_error", 32'(error_m), 32'd0);
        check_val("rst_checksum", 32'(csum_m), 32'd0);
        check_val("rst_we_ready", {30'd0, we_m, ready_m}, 32'd0);
        check_val("rst_addr_wdata", {11'd0, addr_m, wdata_m}, 32'd0);

        // 1: back-to-back stream, mode=1
        clear_log();
        start_main(1'b1, 1);
        stream_beats(0, 30, 1, 1'b0);
        wait_done(0, "t1");
        check_val("t1_error", 32'(error_m), 32'd0);
        check_val("t1_checksum", 32'(csum_m), 32'd465);
        @(posedge clk); #1;
        check_val("t1_done_latency", 32'(done_cyc[0] - last_wr[0]), 32'd62);
        check_seq("t1", 1, 1'b1);
        $display("load t1: writes=%0d checksum=%0d error=%0b", wr_addr_q.size(), csum_m, error_m);

        // 2: random valid gaps, mode=0
        clear_log();
        bad_we = 0;
        start_main(1'b0, 1);
        stream_beats(0, 30, 1, 1'b1);
        wait_done(0, "t2");
        check_val("t2_checksum", 32'(csum_m), 32'd465);
        check_val("t2_error", 32'(error_m), 32'd0);
        @(posedge clk); #1;
        check_seq("t2", 0, 1'b0);
        check_val("t2_we_without_valid", 32'(bad_we), 32'd0);
        $display("load t2: writes=%0d checksum=%0d error=%0b", wr_addr_q.size(), csum_m, error_m);

        // 3: corrupted coefficient at addr 5, then a clean reload
        corrupt = 1'b1;
        start_main(1'b0, 1);
        stream_beats(0, 30, 1, 1'b0);
        wait_done(0, "t3a");
        check_val("t3_error_set", 32'(error_m), 32'd1);
        check_val("t3_checksum", 32'(csum_m), 32'd465);
        @(posedge clk); #1;
        $display("load t3a: checksum=%0d error=%0b", csum_m, error_m);
        corrupt = 1'b0;
        start_main(1'b0, 1);
        @(negedge clk);
        check_val("t3_error_cleared_on_start", 32'(error_m), 32'd0);
        @(posedge clk); #1;
        stream_beats(0, 30, 1, 1'b0);
        wait_done(0, "t3b");
        check_val("t3_error_clean", 32'(error_m), 32'd0);
        @(posedge clk); #1;
        $display("load t3b: checksum=%0d error=%0b", csum_m, error_m);

        // 4: start pulses while busy are ignored
        clear_log();
        d0 = done_cnt[0];
        start_main(1'b0, 1);
        fork
            stream_beats(0, 30, 1, 1'b0);
            begin
                repeat (8) @(posedge clk);
                #1 start_m = 1'b1;
                @(posedge clk); #1 start_m = 1'b0;
            end
        join
        repeat (5) @(posedge clk);
        #1 start_m = 1'b1;
        @(posedge clk); #1 start_m = 1'b0;
        wait_done(0, "t4");
        check_val("t4_checksum", 32'(csum_m), 32'd465);
        @(posedge clk); #1;
        src_valid = 1'b1; src_data = 16'd77;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_val("t4_idle_ready", 32'(ready_m), 32'd0);
        check_val("t4_idle_busy", 32'(busy_m), 32'd0);
        @(posedge clk); #1;
        src_valid = 1'b0;
        check_val("t4_single_done", 32'(done_cnt[0] - d0), 32'd1);
        check_seq("t4", 0, 1'b1);
        $display("load t4: writes=%0d dones=%0d", wr_addr_q.size(), done_cnt[0] - d0);

        // 5: reset after the 10th beat aborts; next load restarts at addr 0
        start_main(1'b0, 1);
        stream_beats(0, 10, 1, 1'b0);
        src_valid = 1'b1; src_data = 16'd11; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("t5_we_after_rst", 32'(we_m), 32'd0);
        check_val("t5_ready_after_rst", 32'(ready_m), 32'd0);
        check_val("t5_busy_after_rst", 32'(busy_m), 32'd0);
        check_val("t5_csum_after_rst", 32'(csum_m), 32'd0);
        @(posedge clk); #1;
        src_valid = 1'b0;
        clear_log();
        start_main(1'b0, 1);
        stream_beats(0, 30, 1, 1'b0);
        wait_done(0, "t5");
        check_val("t5_checksum", 32'(csum_m), 32'd465);
        check_val("t5_error", 32'(error_m), 32'd0);
        @(posedge clk); #1;
        check_seq("t5", 0, 1'b1);
        $display("load t5: writes=%0d checksum=%0d", wr_addr_q.size(), csum_m);

        // 6: single coefficient, RL=0
        w0 = wr_cnt[1];
        @(posedge clk); #1;
        start_a = 1'b1; src_valid = 1'b1; src_data = 16'hFFFF;
        @(posedge clk); #1;
        start_a = 1'b0;
        stream_beats(1, 1, 16'hFFFF, 1'b0);
        wait_done(1, "t6a");
        check_val("t6a_checksum", 32'(csum_a), 32'h0000FFFF);
        check_val("t6a_error", 32'(error_a), 32'd0);
        @(posedge clk); #1;
        check_val("t6a_writes", 32'(wr_cnt[1] - w0), 32'd2);
        check_val("t6a_done_latency", 32'(done_cyc[1] - last_wr[1]), 32'd3);
        $display("load t6a: checksum=0x%0h error=%0b", csum_a, error_a);

        // 6: single coefficient, RL=3
        w0 = wr_cnt[2];
        start_b = 1'b1; src_valid = 1'b1; src_data = 16'hFFFF;
        @(posedge clk); #1;
        start_b = 1'b0;
        stream_beats(2, 1, 16'hFFFF, 1'b0);
        wait_done(2, "t6b");
        check_val("t6b_checksum", 32'(csum_b), 32'h0000FFFF);
        check_val("t6b_error", 32'(error_b), 32'd0);
        @(posedge clk); #1;
        check_val("t6b_writes", 32'(wr_cnt[2] - w0), 32'd2);
        check_val("t6b_done_latency", 32'(done_cyc[2] - last_wr[2]), 32'd6);
        $display("load t6b: checksum=0x%0h error=%0b", csum_b, error_b);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
